// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector, last PAT_W accepted bits vs a loadable pattern, MSB first.
// Define SEQ_DET_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module seq_detector #(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int unsigned      CNT_W   = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
`ifdef SEQ_DET_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             y,
  output logic             armed
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat, pat_n;
  logic [PAT_W-1:0]  hist, hist_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic              y_n;
  logic [PAT_W-1:0]  hist_shift;
  logic              hit;

  assign hist_shift = {hist[PAT_W-2:0], x};
  assign hit        = !cfg_load && in_valid && (hist_shift == pat) && (fill >= FILL_LAST);
  assign armed      = (fill == FILL_FULL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else begin
      pat  <= pat_n;
      hist <= hist_n;
      fill <= fill_n;
      y    <= y_n;
    end
  end

  // Next state: load beats data; fill counts accepted bits since the last restart
  always_comb begin
    pat_n  = pat;
    hist_n = hist;
    fill_n = fill;
    y_n    = 1'b0;
    if (cfg_load) begin
      pat_n  = cfg_pat;
      hist_n = '0;
      fill_n = '0;
    end else if (in_valid) begin
      hist_n = hist_shift;
      if (hit) begin
        y_n    = 1'b1;
        fill_n = overlap ? FILL_FULL : '0;
      end else if (fill != FILL_FULL) begin
        fill_n = fill + FILL_W'(1);
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_cnt <= '0;
    else     match_cnt <= cnt_n;
  end

  // Clear wins over a coincident hit; count saturates rather than wrapping
  always_comb begin
    cnt_n = match_cnt;
    if (cnt_clr)                           cnt_n = '0;
    else if (hit && (match_cnt != CNT_MAX)) cnt_n = match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a bit-history model predicts y/armed/match_cnt per edge.
// Counter checks are active when SEQ_DET_CNT_EN is defined.
module tb_seq_detector;

  localparam int unsigned PAT_W   = 3;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             x, in_valid, overlap, cfg_load, cnt_clr;
  logic [PAT_W-1:0] cfg_pat;
  logic             y, armed;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  always #5 clk = ~clk;

`ifdef SEQ_DET_CNT_EN
  seq_detector #(.PAT_W(PAT_W), .PATTERN(3'b101), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cnt_clr(cnt_clr), .match_cnt(match_cnt),
    .y(y), .armed(armed));
`else
  seq_detector #(.PAT_W(PAT_W), .PATTERN(3'b101)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .y(y), .armed(armed));
`endif

  typedef struct {
    int y;
    int armed;
    int cnt;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  int               stepno = 0;

  // Reference model: list of accepted bits plus count since the last restart
  logic [PAT_W-1:0] m_pat;
  bit               m_bits[$];
  int               m_n;
  int               m_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string when);
    check($sformatf("y@%s", when), int'(y), e.y);
    check($sformatf("armed@%s", when), int'(armed), e.armed);
`ifdef SEQ_DET_CNT_EN
    check($sformatf("match_cnt@%s", when), int'(match_cnt), e.cnt);
`endif
  endtask

  task automatic model_reset();
    m_pat = 3'b101;
    m_bits.delete();
    m_n   = 0;
    m_cnt = 0;
  endtask

  task automatic step(input logic xb, input logic v, input logic ov,
                      input logic ld, input logic [PAT_W-1:0] cp, input logic clr);
    exp_t e;
    bit   hit;
    x        = xb;
    in_valid = v;
    overlap  = ov;
    cfg_load = ld;
    cfg_pat  = cp;
    cnt_clr  = clr;
    hit      = 1'b0;
    if (ld) begin
      m_pat = cp;
      m_bits.delete();
      m_n = 0;
    end else if (v) begin
      m_bits.push_back(xb);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      m_n++;
      if (m_n >= PAT_W) begin
        hit = 1'b1;
        for (int i = 0; i < PAT_W; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      end
      if (hit && !ov) m_n = 0;
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    e.y     = int'(hit);
    e.armed = int'(m_n >= PAT_W);
    e.cnt   = m_cnt;
    sb.push_back(e);

    @(posedge clk);
    #1;
    stepno++;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard@%0d: got empty queue expected an entry", stepno);
    end else begin
      e = sb.pop_front();
      check_outputs(e, $sformatf("%0d", stepno));
    end
  endtask

  task automatic bit_in(input logic xb, input logic ov);
    step(xb, 1'b1, ov, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] p);
    step(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b0);
  endtask

  // Raise rst between edges and check the clear takes effect without a clock
  task automatic async_reset(input string when);
    exp_t e;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    e.y = 0; e.armed = 0; e.cnt = 0;
    check_outputs(e, when);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e0;
    rst = 1'b1; x = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    cfg_load = 1'b0; cfg_pat = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    e0.y = 0; e0.armed = 0; e0.cnt = 0;
    check_outputs(e0, "reset");
    rst = 1'b0;

    // Overlapping 1,0,1,0,1 -> hits on bits 3 and 5
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

    // Non-overlapping: single hit, armed returns after bit 6
    load(3'b101);
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);

    // Pattern spread across invalid gaps
    load(3'b101);
    bit_in(1, 1); idle(4); bit_in(0, 1); idle(4); bit_in(1, 1); idle(2);

    // Load coincides with would-be completing bit, then new pattern 011
    load(3'b101);
    bit_in(1, 1); bit_in(0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0);
    bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);

    // Seven 1s on pattern 111: counter saturates, then clear beats a hit
    load(3'b111);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) bit_in(1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    bit_in(1, 1);

    // Async reset while y and armed are high
    load(3'b101);
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    async_reset("rst_after_hit");

    // Async reset after partial 1,0; lone 1 must not match, then 0,1 completes
    bit_in(1, 1); bit_in(0, 1);
    async_reset("rst_partial");
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

    // Random stream with occasional pattern loads and overlap changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b1, PAT_W'($urandom_range(0, (1 << PAT_W) - 1)), 1'b0);
      else
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'b0, '0, 1'($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
